rr_arb_81: RTL and testbench

RR_ARB_81 -- requirements
Module: rr_arb_81

---
 rtl/rr_arb_81_pkg.sv | 13 +
 rtl/mux_81.sv | 12 +
 rtl/rr_arb_81.sv | 106 ++++++++++
 tb/tb_rr_arb_81.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/rr_arb_81_pkg.sv
// Shared types and sizes for the 8-way round-robin arbiter and its data selector.
package rr_arb_81_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned SEL_W = 3;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/mux_81.sv
// Combinational 8:1 single-bit selector.
module mux_81
    import rr_arb_81_pkg::*;
(
    input  logic [N_REQ-1:0] i,
    input  logic [SEL_W-1:0] sel,
    output logic             y
);

    assign y = i[sel];

endmodule

// File: rtl/rr_arb_81.sv
// Round-robin arbiter over 8 requesters with a per-grant burst limit.
// The selected requester's data bit is routed out through mux_81.
module rr_arb_81
    import rr_arb_81_pkg::*;
#(
    parameter int unsigned BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] i,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             y,
    output logic             valid,
    output logic             busy
);

    state_t             state;
    state_t             state_nxt;
    logic [SEL_W-1:0]   ptr;
    logic [SEL_W-1:0]   base;
    logic [SEL_W-1:0]   win;
    logic [SEL_W-1:0]   idx;
    logic [CNT_W-1:0]   cnt;
    logic               rel;
    logic               arb;
    logic               found;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; a releasing grant searches from the post-release pointer
    always_comb begin
        rel       = 1'b0;
        base      = ptr;
        arb       = 1'b0;
        win       = ptr;
        idx       = ptr;
        found     = 1'b0;
        state_nxt = state;

        if (state == ST_GRANT) begin
            rel  = !req[sel] || (cnt == CNT_W'(BURST)) || !en;
            base = SEL_W'(sel + SEL_W'(1));
        end
        arb = en && (|req) && ((state == ST_IDLE) || rel);

        for (int k = 0; k < int'(N_REQ); k++) begin
            idx = SEL_W'(int'(base) + k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end

        case (state)
            ST_IDLE:  if (arb) state_nxt = ST_GRANT;
            ST_GRANT: if (rel && !arb) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy  = (state == ST_GRANT);
        valid = (state == ST_GRANT) && req[sel];
    end

    // Grant, select, pointer and burst counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt <= '0;
            sel <= '0;
            ptr <= '0;
            cnt <= '0;
        end else begin
            if (rel) begin
                ptr <= SEL_W'(sel + SEL_W'(1));
            end
            if (arb) begin
                sel <= win;
                gnt <= N_REQ'(1) << win;
                cnt <= CNT_W'(1);
            end else if (rel) begin
                gnt <= '0;
            end else if (state == ST_GRANT) begin
                cnt <= CNT_W'(cnt + CNT_W'(1));
            end
        end
    end

    mux_81 u_mux (
        .i   (i),
        .sel (sel),
        .y   (y)
    );

endmodule

// File: tb/tb_rr_arb_81.sv
// Directed self-checking bench for rr_arb_81 with BURST=4.
module tb_rr_arb_81;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic [7:0] i;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       y;
    logic       valid;
    logic       busy;

    int tests  = 0;
    int failed = 0;

    rr_arb_81 #(.BURST(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .req   (req),
        .i     (i),
        .gnt   (gnt),
        .sel   (sel),
        .y     (y),
        .valid (valid),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_grant(input string tag, input logic [2:0] s);
        logic [7:0] one_hot;
        one_hot = 8'(1) << s;
        check({tag, ".sel"},  8'(sel),  8'(s));
        check({tag, ".gnt"},  gnt,      one_hot);
        check({tag, ".busy"}, 8'(busy), 8'd1);
    endtask

    task automatic check_idle(input string tag, input logic [2:0] s);
        check({tag, ".gnt"},   gnt,       8'h00);
        check({tag, ".busy"},  8'(busy),  8'd0);
        check({tag, ".valid"}, 8'(valid), 8'd0);
        check({tag, ".sel"},   8'(sel),   8'(s));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [2:0] exp_sel;

        // Reset held two cycles with all requests pending
        rst = 1'b1; en = 1'b1; req = 8'hFF; i = 8'h00;
        tick();
        tick();
        check_idle("reset", 3'd0);

        // First grant after reset goes to requester 0
        rst = 1'b0;
        tick();
        check_grant("first", 3'd0);
        check("first.valid", 8'(valid), 8'd1);

        // Two requesters alternate in 4-cycle bursts, no idle gap
        req = 8'h81; i = 8'h80;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) tick();
            exp_sel = (((k / 4) % 2) == 1) ? 3'd7 : 3'd0;
            check_grant($sformatf("alt%0d", k), exp_sel);
            check($sformatf("alt%0d.y", k), 8'(y), (exp_sel == 3'd7) ? 8'd1 : 8'd0);
            check($sformatf("alt%0d.valid", k), 8'(valid), 8'd1);
        end

        // Drop req[7] in its second cycle; pointer wraps to 0, search reaches 2
        do_reset();
        req = 8'h80; i = 8'h00;
        tick();
        check_grant("wrap.c1", 3'd7);
        tick();
        check_grant("wrap.c2", 3'd7);
        req = 8'h04;
        #1;
        check("wrap.drop.valid", 8'(valid), 8'd0);
        tick();
        check_grant("wrap.next", 3'd2);
        check("wrap.next.valid", 8'(valid), 8'd1);

        // Lone continuous requester is re-granted with no gap
        do_reset();
        req = 8'h08; i = 8'h08;
        for (int k = 0; k < 12; k++) begin
            tick();
            check_grant($sformatf("lone%0d", k), 3'd3);
            check($sformatf("lone%0d.y", k), 8'(y), 8'd1);
            check($sformatf("lone%0d.valid", k), 8'(valid), 8'd1);
        end
        i = 8'hF7;
        #1;
        check("lone.y_follows_i", 8'(y), 8'd0);

        // Enable dropped mid-grant releases to idle; re-enable resumes at ptr=1
        do_reset();
        req = 8'hFF; i = 8'h00;
        tick();
        check_grant("en.c1", 3'd0);
        tick();
        en = 1'b0;
        tick();
        check_idle("en.off0", 3'd0);
        tick();
        tick();
        check_idle("en.off2", 3'd0);
        en = 1'b1;
        tick();
        check_grant("en.resume", 3'd1);

        // Reset mid-grant of requester 5 clears everything, ptr back to 0
        do_reset();
        req = 8'h20;
        tick();
        check_grant("rst5.c1", 3'd5);
        tick();
        rst = 1'b1; req = 8'hFF;
        tick();
        check_idle("rst5.reset", 3'd0);
        rst = 1'b0;
        tick();
        check_grant("rst5.after", 3'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
